// File: rtl/seq_sender_pkg.sv
// ---------------------------------------------------------------------------
// seq_sender_pkg
// Shared definitions for the queued digit sender:
//   - state_t          : sender state encoding (IDLE / SEND / GAP)
//   - BOARD_*_CYCLES   : default strobe-high / strobe-low lengths for the
//                        12 MHz board (100 ms each)
//   - digit_is_encodable : whether a digit maps to its own code on a bus of
//                        the given width (the all-ones code is reserved)
//   - buzz_tap         : counter bit that drives the buzzer for a digit
// ---------------------------------------------------------------------------
package seq_sender_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int unsigned BOARD_HOLD_CYCLES = 32'd1200000;
    localparam int unsigned BOARD_GAP_CYCLES  = 32'd1200000;

    // Digits at or above the all-ones code of the bus cannot be sent as-is
    // and are transmitted as zero instead.
    function automatic logic digit_is_encodable(input int unsigned digit,
                                                input int unsigned data_w);
        longint unsigned limit;
        limit = (64'd1 << data_w) - 64'd1;
        return (64'(digit) < limit);
    endfunction

    // Higher digits use a slower-toggling counter bit; the tap can never run
    // past the top bit of the phase counter.
    function automatic int unsigned buzz_tap(input int unsigned digit,
                                             input int unsigned tone_base,
                                             input int unsigned cnt_w);
        int unsigned tap;
        tap = digit + tone_base;
        if (tap > cnt_w - 1) begin
            tap = cnt_w - 1;
        end
        return tap;
    endfunction

endpackage

// File: rtl/seq_digit_sender_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO holding queued digits for the sender.
//   hwclk, rst   : clock and asynchronous active-high reset
//   flush        : empties the FIFO; overrides push and pop in the same cycle
//   push, din    : write din when not full (push while full is ignored)
//   pop          : advance the read pointer when not empty
//   head         : entry at the read pointer (valid while !empty)
//   full, empty  : occupancy flags from the registered level
//   level        : number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       hwclk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_write;
    logic             do_read;

    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign head  = mem[rd_ptr_q];

    // Full/empty are judged on the registered level, so a push into a full
    // FIFO is rejected even when a pop frees a slot in the same cycle.
    assign do_write = push && !full && !flush;
    assign do_read  = pop && !empty && !flush;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_write) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_read) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_write, do_read})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: nothing is read from it until it is written.
    always_ff @(posedge hwclk) begin
        if (do_write) begin
            mem[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/seq_digit_sender.sv
// ---------------------------------------------------------------------------
// seq_digit_sender
// Queues up to DEPTH digits from the keypad logic and sends them back to back
// to the Arduino as framed symbols: strobe high for HOLD_CYCLES with the code
// on data_out, then strobe low for GAP_CYCLES with the code still held.
// A buzzer tone, selected per digit, plays while strobe is high.
//   hwclk, rst   : clock and asynchronous active-high reset
//   enable       : transmit permission; low aborts, flushes and clears overflow
//   push/push_num: enqueue a digit; push_ready shows the queue is not full
//   data_out     : encoded symbol (0 for digits that cannot be encoded)
//   strobe       : symbol-valid line, high only in SEND
//   active       : high in SEND or GAP
//   done         : one-cycle pulse after the last queued symbol's gap
//   overflow     : sticky, a push was attempted while the queue was full
//   buzz         : strobe AND phase-counter bit for the current digit
//   level        : queue occupancy
// ---------------------------------------------------------------------------
module seq_digit_sender
    import seq_sender_pkg::*;
#(
    parameter int unsigned NUM_W       = 4,
    parameter int unsigned DATA_W      = 3,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned HOLD_CYCLES = BOARD_HOLD_CYCLES,
    parameter int unsigned GAP_CYCLES  = BOARD_GAP_CYCLES,
    parameter int unsigned TONE_BASE   = 9,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                     hwclk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     push,
    input  logic [NUM_W-1:0]         push_num,
    output logic                     push_ready,
    output logic [DATA_W-1:0]        data_out,
    output logic                     strobe,
    output logic                     active,
    output logic                     done,
    output logic                     overflow,
    output logic                     buzz,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned TAP_W = $clog2(CNT_W);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   counter_q, counter_d;
    logic [DATA_W-1:0]  code_q, code_d;
    logic [TAP_W-1:0]   tap_q, tap_d;
    logic               done_q, done_d;
    logic               overflow_q, overflow_d;

    logic               fifo_pop;
    logic               fifo_flush;
    logic               fifo_full;
    logic               fifo_empty;
    logic [NUM_W-1:0]   fifo_head;
    logic               hold_last;
    logic               gap_last;
    logic [DATA_W-1:0]  head_code;
    logic [TAP_W-1:0]   head_tap;

    sync_fifo #(
        .WIDTH (NUM_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .hwclk (hwclk),
        .rst   (rst),
        .flush (fifo_flush),
        .push  (push),
        .din   (push_num),
        .pop   (fifo_pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign hold_last = (counter_q == CNT_W'(HOLD_CYCLES - 1));
    assign gap_last  = (counter_q == CNT_W'(GAP_CYCLES - 1));

    assign head_code = digit_is_encodable(32'(fifo_head), DATA_W) ? DATA_W'(fifo_head) : '0;
    assign head_tap  = TAP_W'(buzz_tap(32'(fifo_head), TONE_BASE, CNT_W));

    // Next-state logic. Dropping enable wins over everything: the queue is
    // flushed (which also discards a same-cycle push), overflow clears and the
    // sender returns to IDLE without a done pulse. A gap that ends with more
    // digits queued pops straight into the next SEND so frames abut.
    always_comb begin
        state_d    = state_q;
        counter_d  = counter_q;
        code_d     = code_q;
        tap_d      = tap_q;
        done_d     = 1'b0;
        overflow_d = overflow_q;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;

        if (!enable) begin
            state_d    = IDLE;
            counter_d  = '0;
            code_d     = '0;
            overflow_d = 1'b0;
            fifo_flush = 1'b1;
        end else begin
            if (push && fifo_full) begin
                overflow_d = 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        counter_d = '0;
                        state_d   = SEND;
                    end
                end
                SEND: begin
                    if (hold_last) begin
                        counter_d = '0;
                        state_d   = GAP;
                    end else begin
                        counter_d = counter_q + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (gap_last) begin
                        counter_d = '0;
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            state_d  = SEND;
                        end else begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end else begin
                        counter_d = counter_q + CNT_W'(1);
                    end
                end
                default: begin
                    counter_d = '0;
                    state_d   = IDLE;
                end
            endcase
        end

        if (fifo_pop) begin
            code_d = head_code;
            tap_d  = head_tap;
        end
    end

    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            counter_q  <= '0;
            code_q     <= '0;
            tap_q      <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            counter_q  <= counter_d;
            code_q     <= code_d;
            tap_q      <= tap_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

    // data_out is forced to zero in IDLE, so the held code needs no clearing
    // when a sequence completes.
    assign strobe     = (state_q == SEND);
    assign active     = (state_q != IDLE);
    assign data_out   = active ? code_q : '0;
    assign buzz       = strobe && counter_q[tap_q];
    assign done       = done_q;
    assign overflow   = overflow_q;
    assign push_ready = !fifo_full;

endmodule

// File: doc/seq_digit_sender.md
Name: seq_digit_sender

Overview:
- Parametrised successor to the single-digit Arduino sender.
- Queues up to DEPTH digits and transmits them back-to-back on a DATA_W-bit parallel bus with a framing strobe, inter-symbol gap and per-digit buzzer tone.
- Sits between the keypad/entry logic (producer) and the Arduino link pins; signals a one-cycle done when the whole queued sequence has been sent.

Parameters:
- NUM_W, 4: width of queued digit values.
- DATA_W, 3: width of the parallel data bus to the Arduino.
- DEPTH, 8: FIFO entries (power of two, >=2).
- HOLD_CYCLES, 1200000: strobe-high cycles per symbol (>=1).
- GAP_CYCLES, 1200000: strobe-low cycles after each symbol (>=1).
- TONE_BASE, 9: buzz tap index = digit + TONE_BASE, clamped to CNT_W-1.
- CNT_W, 32: phase counter width.

Ports:
- hwclk, in, 1: system clock.
- rst, in, 1: asynchronous active-high reset.
- enable, in, 1: transmit permission; low aborts and flushes.
- push, in, 1: enqueue push_num this cycle.
- push_num, in, NUM_W: digit to enqueue.
- push_ready, out, 1: FIFO not full.
- data_out, out, DATA_W: encoded symbol to Arduino.
- strobe, out, 1: symbol-valid control line.
- active, out, 1: high in SEND or GAP.
- done, out, 1: one-cycle pulse at sequence end.
- overflow, out, 1: sticky, push attempted while full.
- buzz, out, 1: strobe AND counter[tap].
- level, out, $clog2(DEPTH)+1: FIFO occupancy.

Behaviour:
- Reset (async, rst=1): FIFO empty, state IDLE, counter 0.
  - data_out=0, strobe=0, active=0, done=0, overflow=0, level=0, push_ready=1.
- Encoding: digit < 2**DATA_W-1 gives data_out = digit[DATA_W-1:0]; otherwise data_out=0. With the defaults, 0..6 pass and 7..15 map to 0.
- FIFO:
  - push && !full writes; push && full is ignored and sets overflow.
  - Push while full is ignored even if a pop occurs in the same cycle.
  - A push into an empty FIFO is poppable from the next cycle.
  - Pointers wrap modulo DEPTH.
- State machine:
  - IDLE: if enable && !empty, pop the head, register code and tap, counter=0, go to SEND. Outputs take effect the next cycle.
  - SEND: strobe=1, data_out=code, counter++. When counter==HOLD_CYCLES-1, counter=0 and go to GAP. Strobe is high exactly HOLD_CYCLES cycles.
  - GAP: strobe=0, data_out holds code, counter++. When counter==GAP_CYCLES-1:
    - if !empty, pop the next digit and go to SEND with no idle cycle;
    - else go to IDLE, pulse done for 1 cycle, set data_out=0.
- active=1 in SEND or GAP.
- The counter keeps running within a phase, so buzz toggles at rate hwclk/2^(tap+1) only while strobe=1.
- enable low in any state: go to IDLE next cycle.
  - strobe, data_out and counter clear.
  - FIFO is flushed (level=0).
  - overflow clears.
  - No done pulse.
  - A push in the same cycle is dropped.
- enable low in IDLE also flushes, so pushes only persist while enable=1.
- rst mid-symbol: immediate clear of all outputs, regardless of hwclk.
- done and a new push in the same cycle: the push is queued; the next sequence starts from IDLE on the following cycle.

Decomposition:
- Shared package seq_sender_pkg:
  - state encoding IDLE/SEND/GAP;
  - the encode-invalid rule as a function;
  - default HOLD/GAP constants for the 12 MHz board.
- One sub-module: sync_fifo (parametrised NUM_W x DEPTH).
  - Ports: push/pop/flush, full/empty/level.
  - Async active-high rst on hwclk.

Test Plan (HOLD_CYCLES=4, GAP_CYCLES=3, DEPTH=4, others default):
- Single digit: enable=1, push 5 -> strobe high 4 cycles with data_out=3'b101, then 3 gap cycles with data_out=5, then done pulses once, data_out=0, active=0.
- Back-to-back: push 1,2,6 -> three 4-high/3-low strobe frames with no idle cycles between them; done pulses once after the third gap; level decrements at each pop.
- Invalid digits and tone: push 7 then 12 -> data_out=0 for both frames. Push 0 -> buzz equals strobe AND counter[9] (counter[12] for digit 3).
- Overflow: push 5 digits with enable=1 and the first already popped vs. not yet popped -> at most 4 queued; push_ready=0 when level=4; overflow latches 1 on the rejected push.
- Abort: push 3,4; drop enable on the 2nd SEND cycle -> next cycle strobe=0, data_out=0, level=0, overflow=0, no done; re-enable with an empty FIFO -> stays IDLE.
- Async reset: assert rst between clock edges mid-GAP -> all outputs 0 immediately; after release, push 2 -> normal frame.
